// File: rtl/platform_led.sv
// platform_led: Avalon-MM LED output PIO with atomic set/clear aliases.
// The hardware blink engine (mask, period, status) is built only when PLATFORM_LED_BLINK_EN is defined.
module platform_led #(
    parameter int          DATA_W      = 8,
    parameter int          PERIOD_W    = 16,
    parameter logic [31:0] RESET_VALUE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port
);
    localparam logic [DATA_W-1:0] RST = RESET_VALUE[DATA_W-1:0];

    logic              wr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] data_reg;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    assign wr          = chipselect && !write_n;
    assign wd          = writedata[DATA_W-1:0];
    assign unused_bits = ^writedata;

    always_ff @(posedge clk)
        if (!reset_n)
            data_reg <= RST;
        else if (wr)
            data_reg <= address == 3'd0 ? wd :
                        address == 3'd4 ? data_reg | wd :
                        address == 3'd5 ? data_reg & ~wd : data_reg;

    always_ff @(posedge clk)
        readdata <= (!reset_n || !chipselect) ? '0 : rd_mux;

`ifdef PLATFORM_LED_BLINK_EN
    logic [DATA_W-1:0]   mask_reg;
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] wp;
    logic                phase;

    assign wp = writedata[PERIOD_W-1:0];

    // A PERIOD write restarts the half-period and overrides any coinciding expiry.
    always_ff @(posedge clk)
        if (!reset_n) begin
            mask_reg   <= '0;
            period_reg <= '0;
            cnt        <= '0;
            phase      <= 1'b0;
        end else begin
            if (wr && address == 3'd1)
                mask_reg <= wd;
            if (wr && address == 3'd2) begin
                period_reg <= wp;
                cnt        <= wp == '0 ? '0 : wp - PERIOD_W'(1);
                phase      <= 1'b0;
            end else if (period_reg != '0) begin
                if (cnt == '0) begin
                    phase <= !phase;
                    cnt   <= period_reg - PERIOD_W'(1);
                end else
                    cnt <= cnt - PERIOD_W'(1);
            end
        end

    assign out_port = data_reg ^ (mask_reg & {DATA_W{phase}});

    always_comb
        rd_mux = address == 3'd0 ? 32'(data_reg)   :
                 address == 3'd1 ? 32'(mask_reg)   :
                 address == 3'd2 ? 32'(period_reg) :
                 address == 3'd3 ? {30'd0, period_reg != '0, phase} : '0;
`else
    assign out_port = data_reg;

    always_comb
        rd_mux = address == 3'd0 ? 32'(data_reg) : '0;
`endif
endmodule

// File: tb/tb_platform_led.sv
// tb_platform_led: scoreboard bench for platform_led; expected readdata is queued when a read is presented.
module tb_platform_led;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_item_t;

    rd_item_t exp_q[$];
    logic     rd_req = 1'b0;
    logic     rd_pend = 1'b0;
    int       n_chk = 0;
    int       n_err = 0;

    platform_led dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd_req     = 1'b0;
    endtask

    task automatic present_rd(input logic [2:0] a, input logic cs, input string tag, input logic [31:0] exp);
        rd_item_t it;
        address    = a;
        chipselect = cs;
        write_n    = 1'b1;
        rd_req     = 1'b1;
        it.tag     = tag;
        it.exp     = exp;
        exp_q.push_back(it);
    endtask

    task automatic rd(input logic [2:0] a, input logic cs, input string tag, input logic [31:0] exp);
        present_rd(a, cs, tag, exp);
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        rd_req     = 1'b0;
        @(negedge clk);
        idle();
    endtask

    always @(posedge clk) rd_pend <= rd_req;

    always @(negedge clk)
        if (rd_pend) begin
            if (exp_q.size() == 0)
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else begin
                rd_item_t it;
                it = exp_q.pop_front();
                check(it.tag, readdata, it.exp);
            end
        end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        writedata = '0;
        idle();
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out_port), 32'h0);
        check("rst_rdata", readdata, 32'h0);
        reset_n = 1'b1;
        rd(3'd0, 1'b1, "rst_data", 32'h0);

        wr(3'd0, 32'hFFFF_FFA5);
        check("data_out", 32'(out_port), 32'hA5);
        rd(3'd0, 1'b1, "data_rd", 32'hA5);
        rd(3'd0, 1'b0, "cs_low_rd", 32'h0);

        wr(3'd0, 32'h0F);
        wr(3'd4, 32'h30);
        check("outset", 32'(out_port), 32'h3F);
        wr(3'd5, 32'h05);
        check("outclear", 32'(out_port), 32'h3A);
        rd(3'd4, 1'b1, "outset_rd", 32'h0);
        rd(3'd5, 1'b1, "outclr_rd", 32'h0);
        rd(3'd0, 1'b1, "setclr_rd", 32'h3A);

        wr(3'd6, 32'hFF);
        wr(3'd7, 32'hFF);
        check("rsvd_wr", 32'(out_port), 32'h3A);
        rd(3'd6, 1'b1, "rsvd6_rd", 32'h0);
        rd(3'd7, 1'b1, "rsvd7_rd", 32'h0);

        wr(3'd0, 32'h11);
        rd(3'd0, 1'b1, "wr_then_rd", 32'h11);

`ifdef PLATFORM_LED_BLINK_EN
        wr(3'd0, 32'h00);
        wr(3'd1, 32'h81);
        wr(3'd2, 32'd4);
        check("blink_k0", 32'(out_port), 32'h00);
        // Toggles land on edges 4, 8, 12 after the PERIOD write edge.
        for (int k = 1; k <= 15; k++) begin
            if (k == 2) present_rd(3'd3, 1'b1, "status_ph0", 32'h2);
            if (k == 5) present_rd(3'd3, 1'b1, "status_ph1", 32'h3);
            @(negedge clk);
            idle();
            check($sformatf("blink_k%0d", k), 32'(out_port), ((k / 4) % 2) != 0 ? 32'h81 : 32'h00);
        end
        wr(3'd2, 32'd2);
        check("rewrite_no_toggle", 32'(out_port), 32'h00);
        wr(3'd0, 32'h42);
        check("rewrite_hold", 32'(out_port), 32'h42);
        @(negedge clk);
        check("rewrite_toggle", 32'(out_port), 32'hC3);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_blink_rst", 32'(out_port), 32'h00);
        rd(3'd3, 1'b1, "rst_status", 32'h0);
        rd(3'd1, 1'b1, "rst_mask", 32'h0);
        rd(3'd2, 1'b1, "rst_period", 32'h0);
        repeat (4) @(negedge clk);
        check("rst_static", 32'(out_port), 32'h00);
`else
        wr(3'd0, 32'h00);
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'd3);
        wr(3'd3, 32'hFF);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("static_k%0d", k), 32'(out_port), 32'h00);
        end
        rd(3'd1, 1'b1, "nomask_rd", 32'h0);
        rd(3'd2, 1'b1, "noperiod_rd", 32'h0);
        rd(3'd3, 1'b1, "nostatus_rd", 32'h0);
        rd(3'd0, 1'b1, "data_kept", 32'h0);
`endif
        @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
